pp_interpolator_2: RTL and testbench

- Polyphase interpolate-by-2 for the DUC path. It is the transmit-side counterpart of the 2-branch polyphase decimator in the DDC.
- Each accepted input sample feeds two polyphase FIR branches. An output commutator then emits two samples, branch 0 first and then branch 1, under ready/valid flow control.
- A bypass mode passes the input through, rescaled to the output format.

---
 rtl/pp_interp_pkg.sv | 19 +
 rtl/pp_branch_fir.sv | 57 +++++
 rtl/pp_interpolator_2.sv | 114 +++++++++++
 tb/tb_pp_interpolator_2.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pp_interp_pkg.sv
// Shared types and width helpers for the 2-phase polyphase interpolator.
package pp_interp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PH0  = 2'd1,
    PH1  = 2'd2
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Product width plus growth for an n-term sum, plus one guard bit.
  function automatic int out_width(input int dw, input int cw, input int n);
    return dw + cw + $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/pp_branch_fir.sv
// One polyphase branch: tap delay line, combinational MAC, registered result.
module pp_branch_fir #(
  parameter int DW = 16,
  parameter int CW = 16,
  parameter int OW = 35,
  parameter int N  = 3,
  parameter logic [N*CW-1:0] COEFFS = '0
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          load,
  input  logic [DW-1:0] x,
  output logic [OW-1:0] y
);

  // Sample window, newest (x itself) at bits [DW-1:0], sample k at [k*DW +: DW].
  logic [N*DW-1:0] win;

  if (N > 1) begin : g_hist
    logic [(N-1)*DW-1:0] hist_q;
    assign win = {hist_q, x};
    always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
        hist_q <= '0;
      end else if (load) begin
        hist_q <= win[(N-1)*DW-1:0];
      end
    end
  end else begin : g_nohist
    assign win = x;
  end

  logic signed [OW-1:0]    acc;
  logic signed [DW+CW-1:0] prod;

  always_comb begin
    acc  = '0;
    prod = '0;
    for (int k = 0; k < N; k++) begin
      prod = $signed(win[k*DW +: DW]) * $signed(COEFFS[k*CW +: CW]);
      acc  = acc + OW'(prod);
    end
  end

  logic [OW-1:0] y_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      y_q <= '0;
    end else if (load) begin
      y_q <= acc;
    end
  end

  assign y = y_q;

endmodule

// File: rtl/pp_interpolator_2.sv
// Polyphase interpolate-by-2: two FIR branches feeding an output commutator,
// with a combinational bypass path.
module pp_interpolator_2
  import pp_interp_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int N_COEFFS_0  = 3,
  parameter int N_COEFFS_1  = 3,
  parameter logic [N_COEFFS_0*COEFF_WIDTH-1:0] COEFFS_0 = {16'sd3, 16'sd2, 16'sd1},
  parameter logic [N_COEFFS_1*COEFF_WIDTH-1:0] COEFFS_1 = {16'sd6, 16'sd5, 16'sd4},
  localparam int N_MAX     = max_int(N_COEFFS_0, N_COEFFS_1),
  localparam int OUT_WIDTH = out_width(DATA_WIDTH, COEFF_WIDTH, N_MAX)
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  bypass,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_in,
  output logic [OUT_WIDTH-1:0]  data_out,
  output logic                  valid_out,
  input  logic                  ready_out,
  output logic [1:0]            state_dbg_o
);

  // Handshake: a beat moves on a port in any cycle where both valid and ready
  // are high at the clock edge; valid never waits on ready, and a held beat
  // (data and valid) stays stable until it moves.

  state_t state_q, state_d;
  logic   accept;
  logic   transfer;
  logic   load;
  logic [OUT_WIDTH-1:0] y0;
  logic [OUT_WIDTH-1:0] y1;

  assign accept   = valid_in & ready_in;
  assign transfer = valid_out & ready_out;
  // Filters only consume samples outside bypass, so the history survives it.
  assign load     = accept & ~bypass;

  pp_branch_fir #(
    .DW(DATA_WIDTH), .CW(COEFF_WIDTH), .OW(OUT_WIDTH),
    .N(N_COEFFS_0), .COEFFS(COEFFS_0)
  ) u_br0 (
    .clk(clk), .arst_n(arst_n), .load(load), .x(data_in), .y(y0)
  );

  pp_branch_fir #(
    .DW(DATA_WIDTH), .CW(COEFF_WIDTH), .OW(OUT_WIDTH),
    .N(N_COEFFS_1), .COEFFS(COEFFS_1)
  ) u_br1 (
    .clk(clk), .arst_n(arst_n), .load(load), .x(data_in), .y(y1)
  );

  always_comb begin
    state_d = state_q;
    if (bypass) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = PH0;
        PH0:     if (transfer) state_d = PH1;
        PH1:     if (transfer) state_d = accept ? PH0 : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Bypass aligns the input's binary point with a full-scale coefficient product.
  logic signed [DATA_WIDTH+COEFF_WIDTH-2:0] byp_raw;
  assign byp_raw = {data_in, {(COEFF_WIDTH-1){1'b0}}};

  always_comb begin
    ready_in  = 1'b1;
    valid_out = 1'b0;
    data_out  = '0;
    if (bypass) begin
      ready_in  = ready_out;
      valid_out = valid_in;
      data_out  = OUT_WIDTH'(byp_raw);
    end else begin
      case (state_q)
        PH0: begin
          ready_in  = 1'b0;
          valid_out = 1'b1;
          data_out  = y0;
        end
        PH1: begin
          ready_in  = ready_out;
          valid_out = 1'b1;
          data_out  = y1;
        end
        default: begin
          ready_in  = 1'b1;
          valid_out = 1'b0;
          data_out  = '0;
        end
      endcase
    end
  end

  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_pp_interpolator_2.sv
// Directed bench for pp_interpolator_2: impulse, backpressure, throughput,
// bypass, reset in PH1 and the full-scale width corner.
module tb_pp_interpolator_2;

  localparam int DW = 16;
  localparam int CW = 16;
  localparam int OW = 35;

  logic          clk;
  logic          arst_n;
  logic          bypass;
  logic [DW-1:0] data_in;
  logic          valid_in;
  logic          ready_in;
  logic [OW-1:0] data_out;
  logic          valid_out;
  logic          ready_out;
  logic [1:0]    state_dbg;

  logic          wc_valid_in;
  logic [DW-1:0] wc_data_in;
  logic          wc_ready_in;
  logic [OW-1:0] wc_data_out;
  logic          wc_valid_out;
  logic          wc_ready_out;
  logic [1:0]    wc_state_dbg;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] got_q[$];
  logic [DW-1:0] in_q[$];
  logic          vo_q[$];
  logic          ri_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  pp_interpolator_2 #(
    .DATA_WIDTH(DW), .COEFF_WIDTH(CW), .N_COEFFS_0(3), .N_COEFFS_1(3),
    .COEFFS_0({16'sd3, 16'sd2, 16'sd1}),
    .COEFFS_1({16'sd6, 16'sd5, 16'sd4})
  ) dut (
    .clk(clk), .arst_n(arst_n), .bypass(bypass),
    .data_in(data_in), .valid_in(valid_in), .ready_in(ready_in),
    .data_out(data_out), .valid_out(valid_out), .ready_out(ready_out),
    .state_dbg_o(state_dbg)
  );

  pp_interpolator_2 #(
    .DATA_WIDTH(DW), .COEFF_WIDTH(CW), .N_COEFFS_0(3), .N_COEFFS_1(3),
    .COEFFS_0({3{16'h8000}}),
    .COEFFS_1({3{16'h8000}})
  ) dut_wc (
    .clk(clk), .arst_n(arst_n), .bypass(1'b0),
    .data_in(wc_data_in), .valid_in(wc_valid_in), .ready_in(wc_ready_in),
    .data_out(wc_data_out), .valid_out(wc_valid_out), .ready_out(wc_ready_out),
    .state_dbg_o(wc_state_dbg)
  );

  task automatic do_reset();
    arst_n       = 1'b0;
    bypass       = 1'b0;
    valid_in     = 1'b0;
    data_in      = '0;
    ready_out    = 1'b0;
    wc_valid_in  = 1'b0;
    wc_data_in   = '0;
    wc_ready_out = 1'b0;
    repeat (2) @(posedge clk);
    #1 arst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  // Streams in_q with ready_out held as set by the caller; collects outputs.
  task automatic run_stream(input int n_expect, input int max_cyc, output int cycles_used);
    int cyc = 0;
    got_q.delete();
    vo_q.delete();
    ri_q.delete();
    while ((got_q.size() < n_expect) && (cyc < max_cyc)) begin
      valid_in = (in_q.size() > 0);
      data_in  = valid_in ? in_q[0] : '0;
      @(negedge clk);
      vo_q.push_back(valid_out);
      ri_q.push_back(ready_in);
      if (valid_out && ready_out) got_q.push_back(data_out);
      if (valid_in && ready_in) void'(in_q.pop_front());
      @(posedge clk);
      #1;
      cyc++;
    end
    valid_in = 1'b0;
    data_in  = '0;
    cycles_used = cyc;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    arst_n    = 1'b0;
    bypass    = 1'b0;
    valid_in  = 1'b0;
    ready_out = 1'b1;
    #2;
    n_cmp++;
    if (valid_out !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid_out: got %b want 0", valid_out);
    end
    n_cmp++;
    if (data_out !== '0) begin
      n_fail++; $display("FAIL reset_data_out: got %0d want 0", $signed(data_out));
    end
    n_cmp++;
    if (ready_in !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready_in: got %b want 1", ready_in);
    end
    n_cmp++;
    if (state_dbg !== 2'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d want 0", state_dbg);
    end
    do_reset();
  endtask

  task automatic check_stream(input string name, input int cyc_used, input int cyc_want);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s_count: got %0d outputs want %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s_out%0d: got %0d want %0d", name, i, $signed(got_q[i]), $signed(exp_q[i]));
      end
    end
    n_cmp++;
    if (cyc_used != cyc_want) begin
      n_fail++; $display("FAIL %s_cycles: got %0d want %0d", name, cyc_used, cyc_want);
    end
  endtask

  task automatic load_impulse_expect();
    exp_q.delete();
    exp_q.push_back(OW'(100)); exp_q.push_back(OW'(400));
    exp_q.push_back(OW'(200)); exp_q.push_back(OW'(500));
    exp_q.push_back(OW'(300)); exp_q.push_back(OW'(600));
    exp_q.push_back(OW'(0));   exp_q.push_back(OW'(0));
  endtask

  task automatic test_impulse();
    int cyc;
    do_reset();
    ready_out = 1'b1;
    in_q = '{16'd100, 16'd0, 16'd0, 16'd0};
    load_impulse_expect();
    run_stream(8, 40, cyc);
    check_stream("impulse", cyc, 9);
    n_cmp++;
    if (vo_q.size() < 2 || vo_q[0] !== 1'b0 || vo_q[1] !== 1'b1) begin
      n_fail++; $display("FAIL impulse_latency: first output not exactly 1 clk after accept");
    end
    @(negedge clk);
    n_cmp++;
    if (valid_out !== 1'b0 || state_dbg !== 2'd0) begin
      n_fail++; $display("FAIL impulse_idle: got valid %b state %0d want 0 0", valid_out, state_dbg);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    do_reset();
    ready_out = 1'b0;
    valid_in  = 1'b1;
    data_in   = 16'd100;
    @(posedge clk); #1;
    valid_in = 1'b0;
    data_in  = 16'd55;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (valid_out !== 1'b1 || data_out !== OW'(100) || ready_in !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got v=%b d=%0d ri=%b want 1 100 0", i, valid_out, $signed(data_out), ready_in);
      end
      @(posedge clk); #1;
    end
    ready_out = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (valid_out !== 1'b1 || data_out !== OW'(100)) begin
      n_fail++; $display("FAIL bp_release_ph0: got v=%b d=%0d want 1 100", valid_out, $signed(data_out));
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (valid_out !== 1'b1 || data_out !== OW'(400) || ready_in !== 1'b1) begin
      n_fail++; $display("FAIL bp_ph1: got v=%b d=%0d ri=%b want 1 400 1", valid_out, $signed(data_out), ready_in);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (valid_out !== 1'b0) begin
      n_fail++; $display("FAIL bp_no_dup: got valid %b want 0", valid_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int cyc;
    int bad_vo = 0;
    int bad_ri = 0;
    do_reset();
    ready_out = 1'b1;
    in_q = '{16'd1, 16'd2, 16'd3, 16'd4};
    exp_q.delete();
    exp_q.push_back(OW'(1));  exp_q.push_back(OW'(4));
    exp_q.push_back(OW'(4));  exp_q.push_back(OW'(13));
    exp_q.push_back(OW'(10)); exp_q.push_back(OW'(28));
    exp_q.push_back(OW'(16)); exp_q.push_back(OW'(43));
    run_stream(8, 40, cyc);
    check_stream("b2b", cyc, 9);
    for (int i = 1; i < 9 && i < vo_q.size(); i++) if (vo_q[i] !== 1'b1) bad_vo++;
    for (int i = 0; i < 8 && i < ri_q.size(); i++) if (ri_q[i] !== ((i % 2) == 0)) bad_ri++;
    n_cmp++;
    if (bad_vo != 0 || vo_q.size() < 9) begin
      n_fail++; $display("FAIL b2b_valid_cont: got %0d gaps want 0", bad_vo);
    end
    n_cmp++;
    if (bad_ri != 0 || ri_q.size() < 8) begin
      n_fail++; $display("FAIL b2b_ready_toggle: got %0d bad cycles want 0", bad_ri);
    end
  endtask

  task automatic test_bypass();
    int cyc;
    logic [OW-1:0] exp_v;
    do_reset();
    bypass    = 1'b1;
    ready_out = 1'b1;
    valid_in  = 1'b1;
    data_in   = 16'hFFFF;
    #1;
    exp_v = OW'(-32768);
    n_cmp++;
    if (data_out !== exp_v || valid_out !== 1'b1 || ready_in !== 1'b1) begin
      n_fail++;
      $display("FAIL bypass_neg1: got d=%0d v=%b ri=%b want -32768 1 1", $signed(data_out), valid_out, ready_in);
    end
    ready_out = 1'b0;
    valid_in  = 1'b0;
    #1;
    n_cmp++;
    if (ready_in !== 1'b0 || valid_out !== 1'b0 || state_dbg !== 2'd0) begin
      n_fail++;
      $display("FAIL bypass_follow: got ri=%b v=%b st=%0d want 0 0 0", ready_in, valid_out, state_dbg);
    end
    // Enter PH0 with a filtered sample, then let bypass discard it.
    @(posedge clk); #1;
    bypass   = 1'b0;
    valid_in = 1'b1;
    data_in  = 16'd100;
    @(posedge clk); #1;
    bypass    = 1'b1;
    ready_out = 1'b1;
    data_in   = 16'd7;
    #1;
    n_cmp++;
    if (data_out !== OW'(229376)) begin
      n_fail++; $display("FAIL bypass_pos7: got %0d want 229376", $signed(data_out));
    end
    @(posedge clk); #1;
    bypass   = 1'b0;
    valid_in = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (state_dbg !== 2'd0 || valid_out !== 1'b0) begin
      n_fail++; $display("FAIL bypass_discard: got st=%0d v=%b want 0 0", state_dbg, valid_out);
    end
    @(posedge clk); #1;
    in_q = '{16'd0};
    exp_q.delete();
    exp_q.push_back(OW'(200));
    exp_q.push_back(OW'(500));
    run_stream(2, 20, cyc);
    check_stream("bypass_history", cyc, 3);
  endtask

  task automatic test_reset_ph1();
    int cyc;
    do_reset();
    ready_out = 1'b1;
    valid_in  = 1'b1;
    data_in   = 16'd100;
    @(posedge clk); #1;
    valid_in = 1'b0;
    @(posedge clk); #1;
    ready_out = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (state_dbg !== 2'd2 || valid_out !== 1'b1) begin
      n_fail++; $display("FAIL rst_ph1_setup: got st=%0d v=%b want 2 1", state_dbg, valid_out);
    end
    arst_n = 1'b0;
    #1;
    n_cmp++;
    if (valid_out !== 1'b0 || data_out !== '0 || ready_in !== 1'b1 || state_dbg !== 2'd0) begin
      n_fail++;
      $display("FAIL rst_ph1_async: got v=%b d=%0d ri=%b st=%0d want 0 0 1 0", valid_out, $signed(data_out), ready_in, state_dbg);
    end
    @(posedge clk); #1;
    arst_n = 1'b1;
    @(posedge clk); #1;
    ready_out = 1'b1;
    in_q = '{16'd100, 16'd0, 16'd0, 16'd0};
    load_impulse_expect();
    run_stream(8, 40, cyc);
    check_stream("rst_impulse", cyc, 9);
  endtask

  task automatic test_width_corner();
    int cyc = 0;
    int n_in = 0;
    do_reset();
    wc_ready_out = 1'b1;
    exp_q.delete();
    exp_q.push_back(OW'(64'sd1073741824)); exp_q.push_back(OW'(64'sd1073741824));
    exp_q.push_back(OW'(64'sd2147483648)); exp_q.push_back(OW'(64'sd2147483648));
    exp_q.push_back(OW'(64'sd3221225472)); exp_q.push_back(OW'(64'sd3221225472));
    got_q.delete();
    while (got_q.size() < 6 && cyc < 40) begin
      wc_valid_in = (n_in < 3);
      wc_data_in  = wc_valid_in ? 16'h8000 : '0;
      @(negedge clk);
      if (wc_valid_out && wc_ready_out) got_q.push_back(wc_data_out);
      if (wc_valid_in && wc_ready_in) n_in++;
      @(posedge clk); #1;
      cyc++;
    end
    wc_valid_in = 1'b0;
    check_stream("width_corner", cyc, 7);
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_impulse();
    test_backpressure();
    test_back_to_back();
    test_bypass();
    test_reset_ph1();
    test_width_corner();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
